// File: rtl/midori_sbox_seq.sv
// Nibble-serial sequencer feeding a three-share masked Midori S-box with a LATENCY-cycle pipeline.
// Define MIDORI_SEQ_UNMASK_EN to add plain_o, the registered XOR of the three result shares.
module midori_sbox_seq #(
    parameter int          LATENCY = 3,
    parameter logic [44:0] SEED    = 45'h1F0E_D3C2_B1A9
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [63:0] state1_i,
    input  logic [63:0] state2_i,
    input  logic [63:0] state3_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] state1_o,
    output logic [63:0] state2_o,
    output logic [63:0] state3_o,
    output logic [3:0]  sb_in1_o,
    output logic [3:0]  sb_in2_o,
    output logic [3:0]  sb_in3_o,
    output logic [44:0] sb_r_o,
    output logic [5:0]  sb_rs_o,
    input  logic [5:0]  sb_rs_i,
    input  logic [3:0]  sb_out1_i,
    input  logic [3:0]  sb_out2_i,
    input  logic [3:0]  sb_out3_i
`ifdef MIDORI_SEQ_UNMASK_EN
    ,
    output logic [63:0] plain_o
`endif
);

    localparam int CW = ($clog2(LATENCY) > 4) ? $clog2(LATENCY) : 4;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            done_d;
    logic [3:0]      nib;
    logic            feed;
    logic [63:0]     sh1_q, sh2_q, sh3_q;
    logic [59:0]     acc1_q, acc2_q, acc3_q;
    logic [LATENCY-1:0] vld_p;
    logic [3:0]      idx_p [LATENCY];
    logic            cap, last;
    logic [44:0]     lfsr_q;

    function automatic logic [44:0] lfsr_step(input logic [44:0] s);
        return {s[43:0], s[44] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_o  <= done_d;
            cnt_q   <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
        end
    end

    // The completion cycle is not a start slot: a held start_i gives layers 21 cycles apart.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (start_i && !done_o) state_d = FEED;
            FEED:  if (cnt_q == CW'(15)) state_d = DRAIN;
            DRAIN: begin
                if (cnt_q == CW'(LATENCY - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign feed   = (state_q == FEED);
    assign nib    = cnt_q[3:0];

    always_ff @(posedge clk) begin
        if (state_q == IDLE && state_d == FEED) begin
            sh1_q <= state1_i;
            sh2_q <= state2_i;
            sh3_q <= state3_i;
        end
    end

    assign sb_in1_o = feed ? sh1_q[{nib, 2'b00} +: 4] : 4'h0;
    assign sb_in2_o = feed ? sh2_q[{nib, 2'b00} +: 4] : 4'h0;
    assign sb_in3_o = feed ? sh3_q[{nib, 2'b00} +: 4] : 4'h0;

    always_comb begin
        sb_rs_o = 6'h00;
        if (feed && cnt_q == '0)
            sb_rs_o = lfsr_q[5:0] ^ lfsr_q[44:39];
        else if (busy_o)
            sb_rs_o = sb_rs_i;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i)
            lfsr_q <= SEED;
        else if (busy_o)
            lfsr_q <= lfsr_step(lfsr_q);
    end

    assign sb_r_o = lfsr_q;

    // Valid/index delay line matching the S-box latency
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= feed;
            for (int i = 1; i < LATENCY; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        idx_p[0] <= nib;
        for (int i = 1; i < LATENCY; i++)
            idx_p[i] <= idx_p[i-1];
    end

    assign cap  = vld_p[LATENCY-1];
    assign last = cap && (idx_p[LATENCY-1] == 4'hF);

    // Nibbles 0..14 collect here; nibble 15 goes straight into the published result.
    always_ff @(posedge clk) begin
        if (cap && !last) begin
            acc1_q[{idx_p[LATENCY-1], 2'b00} +: 4] <= sb_out1_i;
            acc2_q[{idx_p[LATENCY-1], 2'b00} +: 4] <= sb_out2_i;
            acc3_q[{idx_p[LATENCY-1], 2'b00} +: 4] <= sb_out3_i;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state1_o <= '0;
            state2_o <= '0;
            state3_o <= '0;
        end else if (last) begin
            state1_o <= {sb_out1_i, acc1_q};
            state2_o <= {sb_out2_i, acc2_q};
            state3_o <= {sb_out3_i, acc3_q};
        end
    end

`ifdef MIDORI_SEQ_UNMASK_EN
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i)
            plain_o <= '0;
        else if (last)
            plain_o <= {sb_out1_i, acc1_q} ^ {sb_out2_i, acc2_q} ^ {sb_out3_i, acc3_q};
    end
`endif

endmodule
